// File: rtl/monitor_frame_rx.sv
// ----------------------------------------------------------------------------
// monitor_frame_rx
//
// Frame receiver for the power-monitor path. It drains a show-ahead byte
// FIFO and hunts for a 16-bit header. After the header it collects
// PAYLOAD_BYTES payload bytes, one checksum byte and a 16-bit tail. A good
// frame is published on data_ov with a one-cycle data_valid strobe.
// Checksum, tail and idle-timeout errors produce one-cycle pulses and are
// counted in saturating statistics counters.
//
// Ports:
//   sclk        system clock
//   rst_n       asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   show-ahead FIFO data, valid while fifo_empty=0
//   fifo_rd_en  read strobe; a byte is consumed on each sclk edge while high
//   data_ov     last good payload, first received byte in the MSBs
//   data_valid  one-cycle pulse when data_ov is updated
//   chk_err     one-cycle pulse on checksum mismatch
//   frame_err   one-cycle pulse on tail mismatch or idle timeout
//   busy        high whenever the receiver is not hunting for a header
//   good_cnt    good frames received, saturating
//   err_cnt     chk_err + frame_err events, saturating
// ----------------------------------------------------------------------------
module monitor_frame_rx #(
  parameter int          PAYLOAD_BYTES = 12,
  parameter logic [15:0] HEADER        = 16'h0FF0,
  parameter logic [15:0] TAIL          = 16'hEB90,
  parameter int          CHK_MODE      = 0,
  parameter int          TIMEOUT_CYC   = 1000,
  parameter int          CNT_W         = 16
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  input  logic [7:0]                   fifo_data,
  output logic                         fifo_rd_en,
  output logic [PAYLOAD_BYTES*8-1:0]   data_ov,
  output logic                         data_valid,
  output logic                         chk_err,
  output logic                         frame_err,
  output logic                         busy,
  output logic [CNT_W-1:0]             good_cnt,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
  localparam logic [2:0] S_CHK     = 3'd2;
  localparam logic [2:0] S_TAIL    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]      state_reg;
  logic [7:0]      hr_reg;
  logic [6:0]      byte_cnt_reg;
  logic [7:0]      chk_sum_reg;
  logic [7:0]      chk_rx_reg;
  logic            tail_phase_reg;
  logic            tail_bad_reg;
  logic [TO_W-1:0] idle_cnt_reg;

  logic [7:0]                 chk_next;
  logic [PAYLOAD_BYTES*8-1:0] payload_flat;
  logic                       accept;
  logic                       in_frame;
  logic                       timeout_hit;
  logic                       shift_en;

  assign fifo_rd_en  = !fifo_empty && (state_reg != S_DONE);
  assign accept      = fifo_rd_en;
  assign busy        = (state_reg != S_HUNT);
  assign in_frame    = (state_reg == S_PAYLOAD) || (state_reg == S_CHK) ||
                       (state_reg == S_TAIL);
  // The idle counter has already sat at the limit for a full cycle; the
  // abort wins even if a byte happens to arrive in this same cycle.
  assign timeout_hit = in_frame && (idle_cnt_reg == TO_W'(TIMEOUT_CYC));
  assign shift_en    = (state_reg == S_PAYLOAD) && accept && !timeout_hit;
  assign chk_next    = (CHK_MODE == 1) ? (chk_sum_reg ^ fifo_data)
                                       : (chk_sum_reg + fifo_data);

  // Payload shift register, one byte lane per generate iteration. Lane 0
  // takes the newest byte, so after PAYLOAD_BYTES shifts the first byte of
  // the frame sits in the top lane and lands in the MSBs of data_ov.
  genvar gi;
  generate
    for (gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge sclk or negedge rst_n) begin
          if (!rst_n)        lane_reg <= 8'h00;
          else if (shift_en) lane_reg <= fifo_data;
        end
      end else begin : g_rest
        always_ff @(posedge sclk or negedge rst_n) begin
          if (!rst_n)        lane_reg <= 8'h00;
          else if (shift_en) lane_reg <= g_lane[gi-1].lane_reg;
        end
      end
      assign payload_flat[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_HUNT;
      hr_reg         <= 8'h00;
      byte_cnt_reg   <= 7'd0;
      chk_sum_reg    <= 8'h00;
      chk_rx_reg     <= 8'h00;
      tail_phase_reg <= 1'b0;
      tail_bad_reg   <= 1'b0;
      idle_cnt_reg   <= '0;
      data_ov        <= '0;
      data_valid     <= 1'b0;
      chk_err        <= 1'b0;
      frame_err      <= 1'b0;
      good_cnt       <= '0;
      err_cnt        <= '0;
    end else begin
      data_valid <= 1'b0;
      chk_err    <= 1'b0;
      frame_err  <= 1'b0;

      if (in_frame && !accept) idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
      else                     idle_cnt_reg <= '0;

      if (timeout_hit) begin
        // Abort the frame; hunting resumes from the next FIFO byte.
        state_reg    <= S_HUNT;
        hr_reg       <= 8'h00;
        idle_cnt_reg <= '0;
        frame_err    <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end else begin
        case (state_reg)
          S_HUNT: begin
            if (accept) begin
              if ({hr_reg, fifo_data} == HEADER) begin
                state_reg    <= S_PAYLOAD;
                byte_cnt_reg <= 7'd0;
                chk_sum_reg  <= 8'h00;
              end else begin
                hr_reg <= fifo_data;
              end
            end
          end
          S_PAYLOAD: begin
            if (accept) begin
              chk_sum_reg  <= chk_next;
              byte_cnt_reg <= byte_cnt_reg + 7'd1;
              if (byte_cnt_reg == 7'(PAYLOAD_BYTES - 1)) state_reg <= S_CHK;
            end
          end
          S_CHK: begin
            if (accept) begin
              chk_rx_reg     <= fifo_data;
              tail_phase_reg <= 1'b0;
              tail_bad_reg   <= 1'b0;
              state_reg      <= S_TAIL;
            end
          end
          S_TAIL: begin
            if (accept) begin
              if (!tail_phase_reg) begin
                tail_bad_reg   <= (fifo_data != TAIL[15:8]);
                tail_phase_reg <= 1'b1;
              end else begin
                tail_bad_reg <= tail_bad_reg | (fifo_data != TAIL[7:0]);
                state_reg    <= S_DONE;
              end
            end
          end
          S_DONE: begin
            state_reg <= S_HUNT;
            hr_reg    <= 8'h00;
            // A bad tail means the frame boundary itself is suspect, so it
            // outranks the checksum verdict.
            if (tail_bad_reg) begin
              frame_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else if (chk_rx_reg != chk_sum_reg) begin
              chk_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else begin
              data_ov    <= payload_flat;
              data_valid <= 1'b1;
              if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
            end
          end
          default: begin
            state_reg <= S_HUNT;
            hr_reg    <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monitor_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_monitor_frame_rx
//
// Bench for monitor_frame_rx. Two receivers share one byte stream: one with
// the additive checksum and 16-bit counters, one with the XOR checksum and
// 2-bit counters so counter saturation is reached quickly. Expected pulses,
// payloads and counts come from a frame-level model of what was sent.
// ----------------------------------------------------------------------------
module tb_monitor_frame_rx;

  localparam int PB = 12;
  localparam int TO = 40;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;

  logic        rd0, rd1, dv0, dv1, ce0, ce1, fe0, fe1, busy0, busy1;
  logic [PB*8-1:0] ov0, ov1;
  logic [15:0] gc0, ec0;
  logic [1:0]  gc1, ec1;

  always #5 sclk = ~sclk;

  monitor_frame_rx #(
    .PAYLOAD_BYTES(PB), .HEADER(16'h0FF0), .TAIL(16'hEB90),
    .CHK_MODE(0), .TIMEOUT_CYC(TO), .CNT_W(16)
  ) dut0 (
    .sclk(sclk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd0), .data_ov(ov0), .data_valid(dv0), .chk_err(ce0),
    .frame_err(fe0), .busy(busy0), .good_cnt(gc0), .err_cnt(ec0)
  );

  monitor_frame_rx #(
    .PAYLOAD_BYTES(PB), .HEADER(16'h0FF0), .TAIL(16'hEB90),
    .CHK_MODE(1), .TIMEOUT_CYC(TO), .CNT_W(2)
  ) dut1 (
    .sclk(sclk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd1), .data_ov(ov1), .data_valid(dv1), .chk_err(ce1),
    .frame_err(fe1), .busy(busy1), .good_cnt(gc1), .err_cnt(ec1)
  );

  // tag: 0 plain byte, 1 last byte of a complete frame, 2 last byte before a stall
  typedef struct { logic [7:0] b; int tag; } ent_t;
  typedef struct { logic [PB*8-1:0] ov; logic [7:0] sum; logic [7:0] x;
                   logic [7:0] chk; bit tail_ok; } frm_t;

  ent_t q[$];
  frm_t fq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gate_pct = 0;

  int due [2];
  bit e_dv [2];
  bit e_ce [2];
  bit e_fe [2];
  logic [PB*8-1:0] pend_ov [2];
  logic [PB*8-1:0] m_ov [2];
  int m_gc [2];
  int m_ec [2];
  int cmax [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int tag);
    ent_t e;
    e.b = b;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] pl [PB], input logic [7:0] c, input logic [15:0] tl);
    frm_t f;
    f.ov = '0; f.sum = 8'h00; f.x = 8'h00;
    push_byte(8'h0F, 0);
    push_byte(8'hF0, 0);
    for (int i = 0; i < PB; i++) begin
      f.ov  = {f.ov[PB*8-9:0], pl[i]};
      f.sum = f.sum + pl[i];
      f.x   = f.x ^ pl[i];
      push_byte(pl[i], 0);
    end
    push_byte(c, 0);
    push_byte(tl[15:8], 0);
    push_byte(tl[7:0], 1);
    f.chk = c;
    f.tail_ok = (tl == 16'hEB90);
    fq.push_back(f);
  endtask

  // Outcome of a frame whose last tail byte is accepted on the coming edge.
  task automatic sched_frame();
    frm_t f;
    bit ok;
    f = fq.pop_front();
    for (int d = 0; d < 2; d++) begin
      ok = (d == 0) ? (f.sum == f.chk) : (f.x == f.chk);
      due[d]     = cyc + 2;
      e_fe[d]    = !f.tail_ok;
      e_ce[d]    = f.tail_ok && !ok;
      e_dv[d]    = f.tail_ok && ok;
      pend_ov[d] = f.ov;
    end
  endtask

  // Idle timeout after the byte accepted on the coming edge.
  task automatic sched_timeout();
    for (int d = 0; d < 2; d++) begin
      due[d] = cyc + TO + 2;
      e_fe[d] = 1'b1; e_ce[d] = 1'b0; e_dv[d] = 1'b0;
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      bit edv, ece, efe;
      edv = 1'b0; ece = 1'b0; efe = 1'b0;
      if (cyc == due[d]) begin
        edv = e_dv[d]; ece = e_ce[d]; efe = e_fe[d];
        if (edv) begin
          m_ov[d] = pend_ov[d];
          if (m_gc[d] < cmax[d]) m_gc[d]++;
        end
        if ((ece || efe) && m_ec[d] < cmax[d]) m_ec[d]++;
      end
      if (d == 0) begin
        chk("data_valid0", dv0, edv);
        chk("chk_err0", ce0, ece);
        chk("frame_err0", fe0, efe);
        chk("data_ov0", ov0, m_ov[0]);
        chk("good_cnt0", gc0, m_gc[0]);
        chk("err_cnt0", ec0, m_ec[0]);
      end else begin
        chk("data_valid1", dv1, edv);
        chk("chk_err1", ce1, ece);
        chk("frame_err1", fe1, efe);
        chk("data_ov1", ov1, m_ov[1]);
        chk("good_cnt1", gc1, m_gc[1]);
        chk("err_cnt1", ec1, m_ec[1]);
      end
    end
  endtask

  task automatic step();
    ent_t e;
    bit acc;
    @(negedge sclk);
    fifo_empty = (q.size() == 0) || ($urandom_range(0, 99) < gate_pct);
    fifo_data  = (q.size() != 0) ? q[0].b : 8'h00;
    #1;
    if (fifo_empty) chk("rd_en_when_empty", rd0, 1'b0);
    acc = (rd0 === 1'b1);
    if (acc && q.size() != 0) begin
      e = q.pop_front();
      if (e.tag == 1) sched_frame();
      else if (e.tag == 2) sched_timeout();
    end
    @(posedge sclk);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && q.size() != 0; k++) step();
    chk("drain_bytes_left", q.size(), 0);
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic model_clear();
    q.delete();
    fq.delete();
    for (int d = 0; d < 2; d++) begin
      due[d] = -1; m_ov[d] = '0; m_gc[d] = 0; m_ec[d] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dv"}, {dv0, dv1}, 2'b00);
    chk({tag, "_ce"}, {ce0, ce1}, 2'b00);
    chk({tag, "_fe"}, {fe0, fe1}, 2'b00);
    chk({tag, "_busy"}, {busy0, busy1}, 2'b00);
    chk({tag, "_ov0"}, ov0, 0);
    chk({tag, "_ov1"}, ov1, 0);
    chk({tag, "_cnt"}, {gc0, ec0, gc1, ec1}, 0);
  endtask

  task automatic do_reset();
    @(negedge sclk);
    rst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = 8'h00;
    #1;
    check_zero("reset");
    @(negedge sclk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic rand_frame();
    logic [7:0] pl [PB];
    logic [7:0] s, x, c;
    logic [15:0] tl;
    int k;
    s = 8'h00; x = 8'h00;
    for (int i = 0; i < PB; i++) begin
      pl[i] = 8'($urandom);
      s = s + pl[i];
      x = x ^ pl[i];
    end
    k  = $urandom_range(0, 3);
    c  = (k == 0 || k == 3) ? s : (k == 1) ? x : 8'($urandom);
    tl = (k != 3) ? 16'hEB90 : ($urandom_range(0, 1) ? 16'hEA90 : 16'hEB91);
    push_frame(pl, c, tl);
  endtask

  initial begin
    logic [7:0] seq [PB];
    logic [7:0] g;
    cmax[0] = 65535;
    cmax[1] = 3;
    for (int i = 0; i < PB; i++) seq[i] = 8'(i + 1);
    model_clear();

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_zero("por");
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;

    // Known frame: sum 4E good for additive receiver, XOR receiver sees chk_err
    push_frame(seq, 8'h4E, 16'hEB90);
    drain();
    chk("t1_ov0", ov0, 96'h0102030405060708090A0B0C);
    chk("t1_good0", gc0, 1);
    chk("t1_err1", ec1, 1);

    // Checksum 0C: XOR receiver accepts, additive receiver flags chk_err
    push_frame(seq, 8'h0C, 16'hEB90);
    drain();
    chk("t2_ov1", ov1, 96'h0102030405060708090A0B0C);
    chk("t2_err0", ec0, 1);

    // Sliding header match after garbage 0F 0F
    push_byte(8'h0F, 0);
    push_byte(8'h0F, 0);
    push_frame(seq, 8'h4E, 16'hEB90);
    drain();
    chk("t3_good0", gc0, 2);

    // Bad tail, then an immediately following good frame
    push_frame(seq, 8'h4E, 16'hEB91);
    push_frame(seq, 8'h0C, 16'hEB90);
    drain();

    // Stall mid-payload until the idle timeout fires
    push_byte(8'h0F, 0);
    push_byte(8'hF0, 0);
    for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i), (i == 4) ? 2 : 0);
    for (int k = 0; k < 100 && q.size() != 0; k++) step();
    chk("t5_busy_stalled", {busy0, busy1}, 2'b11);
    for (int k = 0; k < TO + 6; k++) step();
    chk("t5_busy_after", {busy0, busy1}, 2'b00);
    push_frame(seq, 8'h4E, 16'hEB90);
    drain();

    // Randomized frames with garbage and FIFO stalls; XOR receiver saturates
    gate_pct = 30;
    for (int n = 0; n < 40; n++) begin
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h0F) g = 8'h10;
        push_byte(g, 0);
      end
      rand_frame();
    end
    drain();
    gate_pct = 0;

    // Reset in the middle of a payload
    push_byte(8'h0F, 0);
    push_byte(8'hF0, 0);
    for (int i = 0; i < 5; i++) push_byte(8'(i), 0);
    for (int k = 0; k < 100 && q.size() != 0; k++) step();
    step();
    chk("t6_busy_mid", {busy0, busy1}, 2'b11);
    do_reset();
    for (int k = 0; k < 3; k++) step();
    push_frame(seq, 8'h4E, 16'hEB90);
    drain();
    chk("t6_good0", gc0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
